// File: rtl/spi_ctrl_if_pkg.sv
// Shared equalizer parameters: band count, frame size and SPI front-end state encoding.
// The gain register map and the SPI write interface both use these values.
package spi_ctrl_if_pkg;

    localparam int EQ_NUM_BANDS  = 10;
    localparam int EQ_FRAME_BITS = 16;
    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 8;
    localparam int SYNC_SETTLE   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_e;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a, input int num_bands);
        return int'({24'd0, a}) < num_bands;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; RST_VAL is the line's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_ctrl_if.sv
// SPI mode-0 slave that turns 16-bit {band, gain} frames into single-cycle gain register writes
// and shifts the last accepted gain code back out on MISO during the next frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cs_n to fall; miso held 0
// ST_SHIFT  | frame in progress; mosi shifted in, last gain shifted out
// ST_COMMIT | one cycle after cs_n rise; we pulses here if frame accepted
module spi_ctrl_if
    import spi_ctrl_if_pkg::*;
#(
    parameter int NUM_BANDS  = EQ_NUM_BANDS,
    parameter int FRAME_BITS = EQ_FRAME_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_d, cs_n_d;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_n_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_n_s & cs_n_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;

    spi_state_e            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_q;
    logic [DATA_W-1:0]     miso_sr;
    logic [1:0]            settle_q;
    logic                  armed_q;

    logic frame_ok;
    assign frame_ok = (bit_cnt == CNT_FULL)
                    && addr_in_range(shift_q[FRAME_BITS-1 -: ADDR_W], NUM_BANDS);

    // The synchronizers come out of reset showing cs_n high; armed_q waits for them to flush so a
    // frame already running at reset release cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_d    <= 1'b0;
            cs_n_d    <= 1'b1;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_q   <= '0;
            miso_sr   <= '0;
            settle_q  <= 2'(SYNC_SETTLE);
            armed_q   <= 1'b0;
            spi_miso  <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            data_in   <= '0;
            frame_err <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_n_d <= cs_n_s;
            we     <= 1'b0;

            if (settle_q != 2'd0) begin
                settle_q <= settle_q - 2'd1;
            end else if (cs_n_s) begin
                armed_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall && armed_q) begin
                        state    <= ST_SHIFT;
                        bit_cnt  <= '0;
                        shift_q  <= '0;
                        miso_sr  <= data_in;
                        spi_miso <= data_in[DATA_W-1];
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state    <= ST_COMMIT;
                        spi_miso <= 1'b0;
                        if (frame_ok) begin
                            we        <= 1'b1;
                            addr      <= shift_q[FRAME_BITS-1 -: ADDR_W];
                            data_in   <= shift_q[DATA_W-1:0];
                            frame_err <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], mosi_s};
                            if (bit_cnt != CNT_SAT) begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (sclk_fall) begin
                            miso_sr  <= {miso_sr[DATA_W-2:0], 1'b0};
                            spi_miso <= miso_sr[DATA_W-2];
                        end
                    end
                end
                ST_COMMIT: begin
                    state    <= ST_IDLE;
                    spi_miso <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    spi_miso <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ctrl_if.sv
// Directed bench for spi_ctrl_if: a table of frames with hand-computed register-map results,
// plus hand-written MISO readback and mid-frame reset sequences.
module tb_spi_ctrl_if;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       frame_err;

    spi_ctrl_if dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .we        (we),
        .addr      (addr),
        .data_in   (data_in),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int we_pulses = 0;
    int we_long = 0;
    logic we_prev = 1'b0;

    always @(negedge clk) begin
        if (we) we_pulses++;
        if (we && we_prev) we_long++;
        we_prev = we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half_period();
        repeat (5) @(negedge clk);
    endtask

    // Sends the low nbits of word MSB first; returns the first 16 MISO bits seen at SCLK rises,
    // the write-strobe count during the frame and the clk latency from raw cs_n rise to we.
    task automatic send_frame(input logic [16:0] word, input int nbits,
                              output logic [15:0] miso_bits, output int pulses, output int lat);
        int p0;
        int k;
        p0 = we_pulses;
        miso_bits = '0;
        k = 0;
        lat = 0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = word[i];
            half_period();
            spi_sclk = 1'b1;
            if (k < 16) miso_bits[15-k] = spi_miso;
            k++;
            half_period();
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        half_period();
        spi_cs_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (we && lat == 0) lat = c;
        end
        pulses = we_pulses - p0;
    endtask

    typedef struct {
        logic [16:0] word;
        int          nbits;
        bit          exp_we;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [15:0] miso_bits;
        logic [15:0] miso_mask;
        logic [7:0]  last_data;
        int pulses;
        int lat;

        vecs[0]  = '{17'h00001, 16, 1'b1, 8'h00, 8'h01, 1'b0};
        vecs[1]  = '{17'h00921, 16, 1'b1, 8'h09, 8'h21, 1'b0};
        vecs[2]  = '{17'h0030D, 16, 1'b1, 8'h03, 8'h0D, 1'b0};
        vecs[3]  = '{17'h00A05, 16, 1'b0, 8'h03, 8'h0D, 1'b1};
        vecs[4]  = '{17'h00105, 16, 1'b1, 8'h01, 8'h05, 1'b0};
        vecs[5]  = '{17'h01234, 15, 1'b0, 8'h01, 8'h05, 1'b1};
        vecs[6]  = '{17'h00277, 16, 1'b1, 8'h02, 8'h77, 1'b0};
        vecs[7]  = '{17'h00406, 17, 1'b0, 8'h02, 8'h77, 1'b1};
        vecs[8]  = '{17'h00000,  0, 1'b0, 8'h02, 8'h77, 1'b1};
        vecs[9]  = '{17'h009FF, 16, 1'b1, 8'h09, 8'hFF, 1'b0};
        vecs[10] = '{17'h0FF00, 16, 1'b0, 8'h09, 8'hFF, 1'b1};
        vecs[11] = '{17'h005A5, 16, 1'b1, 8'h05, 8'hA5, 1'b0};

        repeat (4) @(negedge clk);
        chk("reset_we", {31'd0, we}, 32'd0);
        chk("reset_addr", {24'd0, addr}, 32'd0);
        chk("reset_data", {24'd0, data_in}, 32'd0);
        chk("reset_err", {31'd0, frame_err}, 32'd0);
        chk("reset_miso", {31'd0, spi_miso}, 32'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        last_data = 8'h00;
        for (int v = 0; v < 12; v++) begin
            send_frame(vecs[v].word, vecs[v].nbits, miso_bits, pulses, lat);
            chk($sformatf("v%0d_we_pulses", v), pulses, vecs[v].exp_we ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_addr", v), {24'd0, addr}, {24'd0, vecs[v].exp_addr});
            chk($sformatf("v%0d_data", v), {24'd0, data_in}, {24'd0, vecs[v].exp_data});
            chk($sformatf("v%0d_err", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_idle_miso", v), {31'd0, spi_miso}, 32'd0);
            if (vecs[v].exp_we) begin
                chk($sformatf("v%0d_latency_ok", v), {31'd0, (lat >= 2 && lat <= 4)}, 32'd1);
            end
            if (vecs[v].nbits > 0) begin
                miso_mask = (vecs[v].nbits >= 16) ? 16'hFFFF : ~(16'hFFFF >> vecs[v].nbits);
                chk($sformatf("v%0d_miso_seq", v), {16'd0, miso_bits & miso_mask},
                    {16'd0, {last_data, 8'h00} & miso_mask});
            end
            if (vecs[v].exp_we) last_data = vecs[v].exp_data;
            repeat (3) @(negedge clk);
        end

        // Readback of 0xA5 during the next frame.
        send_frame(17'h0043C, 16, miso_bits, pulses, lat);
        chk("readback_miso_A5", {16'd0, miso_bits}, 32'h0000A500);
        chk("readback_we_pulses", pulses, 32'd1);
        chk("readback_addr", {24'd0, addr}, 32'h04);
        chk("readback_data", {24'd0, data_in}, 32'h3C);

        // Reset after 8 bits, released while cs_n still low: the frame must die silently.
        begin
            logic [15:0] rword;
            int p0;
            int miso_seen;
            rword = 16'h0744;
            p0 = we_pulses;
            miso_seen = 0;
            spi_cs_n = 1'b0;
            repeat (6) @(negedge clk);
            for (int i = 15; i >= 8; i--) begin
                spi_mosi = rword[i];
                half_period();
                spi_sclk = 1'b1;
                half_period();
                spi_sclk = 1'b0;
            end
            rst = 1'b0;
            repeat (3) @(negedge clk);
            chk("midrst_addr", {24'd0, addr}, 32'd0);
            chk("midrst_data", {24'd0, data_in}, 32'd0);
            chk("midrst_miso", {31'd0, spi_miso}, 32'd0);
            rst = 1'b1;
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = rword[i];
                half_period();
                spi_sclk = 1'b1;
                if (spi_miso) miso_seen++;
                half_period();
                spi_sclk = 1'b0;
            end
            spi_mosi = 1'b0;
            half_period();
            spi_cs_n = 1'b1;
            repeat (12) @(negedge clk);
            chk("midrst_we_pulses", we_pulses - p0, 32'd0);
            chk("midrst_err", {31'd0, frame_err}, 32'd0);
            chk("midrst_addr_after", {24'd0, addr}, 32'd0);
            chk("midrst_data_after", {24'd0, data_in}, 32'd0);
            chk("midrst_miso_ones", miso_seen, 32'd0);
        end

        repeat (3) @(negedge clk);
        send_frame(17'h00209, 16, miso_bits, pulses, lat);
        chk("post_rst_we_pulses", pulses, 32'd1);
        chk("post_rst_addr", {24'd0, addr}, 32'h02);
        chk("post_rst_data", {24'd0, data_in}, 32'h09);
        chk("post_rst_err", {31'd0, frame_err}, 32'd0);
        chk("post_rst_miso", {16'd0, miso_bits}, 32'd0);

        chk("we_single_cycle", we_long, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
